dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Per-node data-memory responder: the memory end of a core's DMEM interface (addr_out, d_out, memEn, memWrEn are inputs here; d_in is the output).
- One instance per core in the cardinal CMP test harness and top-level integration.
- Single-port, fixed-latency, unhandshaked: the core never stalls, so read data must arrive exactly RD_LAT cycles after the request.
- Also provides a testbench preload port, out-of-range detection and access counters.

Parameters:
- DATA_WIDTH, 64, word width in bits.
- ADDR_WIDTH, 32, width of the core address bus.
- INDEX_WIDTH, 8, log2 of the array depth (depth 256 words).
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  ADDR_WIDTH  word address from the core.
- mem_wdata  in  DATA_WIDTH  store data from the core.
- mem_en  in  1  access request.
- mem_wr_en  in  1  1 = store, 0 = load; qualified by mem_en.
- mem_rdata  out  DATA_WIDTH  load data to the core.
- ld_en  in  1  preload write strobe.
- ld_addr  in  INDEX_WIDTH  preload index.
- ld_data  in  DATA_WIDTH  preload data.
- err_oor  out  1  sticky out-of-range flag.
- err_addr  out  ADDR_WIDTH  first offending address.
- rd_cnt  out  32  completed-load count.
- wr_cnt  out  32  completed-store count.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: mem_rdata=0, err_oor=0, err_addr=0, rd_cnt=0, wr_cnt=0, read pipeline valid bits=0.
- Reset does not clear the array; array contents are undefined until written or preloaded.
- Address decode:
  - index = mem_addr[INDEX_WIDTH-1:0].
  - In range iff mem_addr[ADDR_WIDTH-1:INDEX_WIDTH] == 0.
- Load (mem_en=1, mem_wr_en=0, in range), sampled at edge N:
  - mem_rdata = array[index] after edge N+RD_LAT-1, i.e. valid in cycle N+RD_LAT.
  - mem_rdata holds that value until the next load completes.
  - rd_cnt increments when the load completes.
- Store (mem_en=1, mem_wr_en=1, in range): array[index] <= mem_wdata at edge N; mem_rdata unchanged; wr_cnt increments at the same edge.
- mem_wr_en with mem_en=0: no effect.
- Store at N then load of the same address at N+1: returns the new data. The single port makes this natural; no forwarding logic is required.
- RD_LAT=2:
  - Read data passes through one extra register stage.
  - Back-to-back loads are fully pipelined, one result per cycle, in request order.
- Out-of-range access:
  - Store is dropped.
  - Load completes on schedule with mem_rdata=0 and rd_cnt incremented.
  - err_oor set to 1 (sticky until reset).
  - err_addr captures mem_addr only on the first event.
  - A second error in a later cycle leaves err_addr unchanged.
- Preload (ld_en=1): array[ld_addr] <= ld_data at the edge.
  - ld_en has priority over a core store in the same cycle: the core store is dropped and wr_cnt is not incremented.
  - A core load in the same cycle still executes and returns the pre-edge contents.
- Counters saturate at 0xFFFF_FFFF; no wrap-around.
- Reset asserted mid-operation: loads in flight are discarded; mem_rdata=0 on the cycle after reset is sampled high.
- Reset versus preload: with reset=1 and ld_en=1 in the same cycle, the preload still writes.

Decomposition:
- Shared package cmp_pkg:
  - DATA_WIDTH, ADDR_WIDTH defaults.
  - Counter width (32) and the saturation constant.
- One sub-module, dmem_array: single-port synchronous-read register array with a write-priority mux (preload over core).
- The top level holds the decode, the latency pipeline, the error capture and the counters.

Test Plan:
1. Reset, preload idx 5 = 0xDEAD_BEEF_0000_0001, load addr 5 at cycle 10 -> mem_rdata=0xDEAD_BEEF_0000_0001 in cycle 11 (RD_LAT=1) or cycle 12 (RD_LAT=2); rd_cnt=1.
2. Store 0x1234 to addr 7 at cycle N, load addr 7 at N+1 -> mem_rdata=0x1234 in cycle N+1+RD_LAT; wr_cnt=1.
3. RD_LAT=2: loads to addrs 1, 2, 3 on consecutive cycles, preloaded with 0xA, 0xB, 0xC -> mem_rdata = 0xA, 0xB, 0xC on three consecutive cycles starting 2 cycles after the first request.
4. Load addr 0x100, then store to addr 0x2000 -> first load returns 0; err_oor=1; err_addr=0x100 (unchanged after the store); the store does not alter the array or wr_cnt.
5. Same cycle ld_en with idx 9 = 0x55 and core store 0x66 to addr 9 -> a later load of addr 9 returns 0x55; wr_cnt unchanged.
6. Load issued, reset asserted the next cycle -> mem_rdata=0, rd_cnt=0, err_oor=0; array data still readable after reset deasserts.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared defaults for the CMP memory-side blocks: bus widths and the
// saturating access-counter helper.
package cmp_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W      = 32;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with a synchronous read register.
// Preload writes win over core stores in the same cycle.
module dmem_array #(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   we,
  input  logic                   rd_en,
  input  logic                   rd_zero,
  input  logic                   ld_en,
  input  logic [INDEX_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [2**INDEX_WIDTH];

  // No reset on the storage: preload must still land while reset is high.
  always_ff @(posedge clk) begin
    if (ld_en)   mem[ld_addr] <= ld_data;
    else if (we) mem[addr]    <= wdata;
  end

  // Read register only updates on a load, so it holds the last result.
  always_ff @(posedge clk) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= rd_zero ? '0 : mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of a core DMEM port: fixed-latency loads, stores, preload,
// out-of-range capture and saturating access counters.
module dmem_responder
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int INDEX_WIDTH = 8,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_en,
  input  logic                   mem_wr_en,
  output logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   ld_en,
  input  logic [INDEX_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic                   err_oor,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt
);

  logic                   in_range;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   rd_req;
  logic                   wr_ok;
  logic                   oor_ev;
  logic [DATA_WIDTH-1:0]  arr_rdata;
  logic [RD_LAT-1:0]      vld_pipe;

  assign idx      = mem_addr[INDEX_WIDTH-1:0];
  assign in_range = (mem_addr[ADDR_WIDTH-1:INDEX_WIDTH] == '0);
  assign rd_req   = mem_en & ~mem_wr_en;
  assign wr_ok    = mem_en & mem_wr_en & in_range & ~ld_en;
  assign oor_ev   = mem_en & ~in_range;

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .addr   (idx),
    .wdata  (mem_wdata),
    .we     (wr_ok),
    .rd_en  (rd_req),
    .rd_zero(~in_range),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .rdata  (arr_rdata)
  );

  // vld_pipe[0] is the load issued this cycle; the top bit is the load
  // completing at the coming edge.
  if (RD_LAT == 2) begin : g_lat2
    logic                  vld_s2;
    logic [DATA_WIDTH-1:0] rdata_s2;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_s2   <= 1'b0;
        rdata_s2 <= '0;
      end else begin
        vld_s2 <= rd_req;
        if (vld_s2) rdata_s2 <= arr_rdata;
      end
    end

    assign vld_pipe  = {vld_s2, rd_req};
    assign mem_rdata = rdata_s2;
  end else begin : g_lat1
    assign vld_pipe  = rd_req;
    assign mem_rdata = arr_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (vld_pipe[RD_LAT-1]) rd_cnt <= sat_inc(rd_cnt);
      if (wr_ok)              wr_cnt <= sat_inc(wr_cnt);
    end
  end

  // err_addr latches only the first offender; later ones just keep the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_oor  <= 1'b0;
      err_addr <= '0;
    end else if (oor_ev) begin
      err_oor <= 1'b1;
      if (!err_oor) err_addr <= mem_addr;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench driving RD_LAT=1 and RD_LAT=2 responders in lockstep.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_en, mem_wr_en, ld_en;
  logic [7:0]  ld_addr;
  logic [63:0] ld_data;

  logic [63:0] rdata_a, rdata_b;
  logic        err_a, err_b;
  logic [31:0] eaddr_a, eaddr_b, rdc_a, rdc_b, wrc_a, wrc_b;

  always #5 clk = ~clk;

  dmem_responder #(.RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rdata(rdata_a),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .err_oor(err_a), .err_addr(eaddr_a), .rd_cnt(rdc_a), .wr_cnt(wrc_a));

  dmem_responder #(.RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rdata(rdata_b),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .err_oor(err_b), .err_addr(eaddr_b), .rd_cnt(rdc_b), .wr_cnt(wrc_b));

  typedef struct {
    int          due;
    logic [63:0] d;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] mdl [256];
  int          rd_exp, wr_exp;
  logic        err_exp;
  logic [31:0] ea_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Loads are unhandshaked: each expected result is tagged with the cycle
  // in which it must be on mem_rdata.
  always @(negedge clk) begin
    if (q_a.size() > 0 && q_a[0].due <= cyc) begin
      checks++;
      if (q_a[0].due != cyc || rdata_a !== q_a[0].d) begin
        errors++;
        $display("FAIL rdata_lat1 cyc=%0d got=%h want=%h (due %0d)", cyc, rdata_a, q_a[0].d, q_a[0].due);
      end
      void'(q_a.pop_front());
    end
    if (q_b.size() > 0 && q_b[0].due <= cyc) begin
      checks++;
      if (q_b[0].due != cyc || rdata_b !== q_b[0].d) begin
        errors++;
        $display("FAIL rdata_lat2 cyc=%0d got=%h want=%h (due %0d)", cyc, rdata_b, q_b[0].d, q_b[0].due);
      end
      void'(q_b.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_rdcnt_a"}, 64'(rdc_a), 64'(rd_exp));
    chk({tag, "_rdcnt_b"}, 64'(rdc_b), 64'(rd_exp));
    chk({tag, "_wrcnt_a"}, 64'(wrc_a), 64'(wr_exp));
    chk({tag, "_wrcnt_b"}, 64'(wrc_b), 64'(wr_exp));
    chk({tag, "_err_a"}, 64'(err_a), 64'(err_exp));
    chk({tag, "_err_b"}, 64'(err_b), 64'(err_exp));
    chk({tag, "_eaddr_a"}, 64'(eaddr_a), 64'(ea_exp));
    chk({tag, "_eaddr_b"}, 64'(eaddr_b), 64'(ea_exp));
  endtask

  // One cycle of stimulus; the model is updated with the same priorities
  // the block must honour, reading before writing.
  task automatic step(input logic en, input logic we, input logic [31:0] a,
                      input logic [63:0] wd, input logic le,
                      input logic [7:0] la, input logic [63:0] ldd);
    exp_t e;
    logic inr;
    inr = (a[31:8] == 24'h0);
    if (en && !we) begin
      e.d   = inr ? mdl[a[7:0]] : 64'h0;
      e.due = cyc + 1;
      q_a.push_back(e);
      e.due = cyc + 2;
      q_b.push_back(e);
      rd_exp++;
    end
    if (en && !inr && !err_exp) begin
      err_exp = 1'b1;
      ea_exp  = a;
    end
    if (le) mdl[la] = ldd;
    else if (en && we && inr) begin
      mdl[a[7:0]] = wd;
      wr_exp++;
    end
    mem_en = en; mem_wr_en = we; mem_addr = a; mem_wdata = wd;
    ld_en = le; ld_addr = la; ld_data = ldd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 8'h0, 64'h0);
  endtask

  task automatic pre(input logic [7:0] la, input logic [63:0] ldd);
    step(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, la, ldd);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b1, 1'b0, a, 64'h0, 1'b0, 8'h0, 64'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [63:0] wd);
    step(1'b1, 1'b1, a, wd, 1'b0, 8'h0, 64'h0);
  endtask

  // One reset cycle, optionally with a preload; results still in flight
  // at the reset edge must come out as zero.
  task automatic pulse_reset(input logic le, input logic [7:0] la, input logic [63:0] ldd);
    for (int i = 0; i < q_a.size(); i++) if (q_a[i].due >= cyc + 1) q_a[i].d = 64'h0;
    for (int i = 0; i < q_b.size(); i++) if (q_b[i].due >= cyc + 1) q_b[i].d = 64'h0;
    if (le) mdl[la] = ldd;
    reset = 1'b1;
    mem_en = 1'b0; mem_wr_en = 1'b0; ld_en = le; ld_addr = la; ld_data = ldd;
    @(posedge clk); #1;
    reset = 1'b0; ld_en = 1'b0;
    rd_exp = 0; wr_exp = 0; err_exp = 1'b0; ea_exp = 32'h0;
  endtask

  initial begin
    rd_exp = 0; wr_exp = 0; err_exp = 1'b0; ea_exp = 32'h0;
    reset = 1'b1;
    mem_addr = '0; mem_wdata = '0; mem_en = 1'b0; mem_wr_en = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rdata_a", rdata_a, 64'h0);
    chk("rst_rdata_b", rdata_b, 64'h0);
    chk_state("rst");

    // Preload then load
    pre(8'd5, 64'hDEAD_BEEF_0000_0001);
    load(32'd5);
    idle(3);
    chk_state("t1");

    // Store then load same address next cycle
    store(32'd7, 64'h1234);
    load(32'd7);
    idle(3);
    chk_state("t2");

    // Back-to-back loads, one result per cycle
    pre(8'd1, 64'hA);
    pre(8'd2, 64'hB);
    pre(8'd3, 64'hC);
    load(32'd1);
    load(32'd2);
    load(32'd3);
    idle(3);
    chk_state("t3");

    // Out-of-range load, then out-of-range store aliasing index 0
    pre(8'd0, 64'h77);
    load(32'h100);
    idle(1);
    store(32'h2000, 64'hFFFF);
    load(32'd0);
    idle(3);
    chk_state("t4");

    // Preload wins over a same-cycle core store
    step(1'b1, 1'b1, 32'd9, 64'h66, 1'b1, 8'd9, 64'h55);
    load(32'd9);
    idle(3);
    chk_state("t5");

    // Same-cycle preload and load returns the pre-edge word
    step(1'b1, 1'b0, 32'd5, 64'h0, 1'b1, 8'd5, 64'h99);
    load(32'd5);
    idle(3);

    // Reset with a load in flight, plus a preload during reset
    load(32'd7);
    pulse_reset(1'b1, 8'd10, 64'hAB);
    chk("mid_rst_rdata_a", rdata_a, 64'h0);
    chk_state("t6");
    idle(2);
    chk("post_rst_rdata_b", rdata_b, 64'h0);
    load(32'd9);
    load(32'd10);
    idle(3);
    chk_state("t6b");

    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) idle(1);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain pending_a=%0d pending_b=%0d want 0", q_a.size(), q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
